// File: rtl/err_pkg.sv
// err_pkg: shared types and constants for the steering-error block.
//   state_t      : round sequencer states
//   CH_*         : A2D channel numbers, fixed conversion order
//   SH_*         : weight shifts (inner x1, mid x2, outer x4)
//   ERR_MAX/MIN  : 11-bit signed saturation limits
//   weigh()      : signed, weighted contribution of one reading
//   saturate()   : clamp of the 16-bit accumulator to 11 bits
package err_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, DONE} state_t;

    localparam int unsigned ACC_W = 16;

    localparam logic [2:0] CH_IN_L  = 3'd0;
    localparam logic [2:0] CH_IN_R  = 3'd1;
    localparam logic [2:0] CH_MID_L = 3'd2;
    localparam logic [2:0] CH_MID_R = 3'd3;
    localparam logic [2:0] CH_OUT_L = 3'd4;
    localparam logic [2:0] CH_OUT_R = 3'd5;

    localparam int unsigned SH_IN  = 0;
    localparam int unsigned SH_MID = 1;
    localparam int unsigned SH_OUT = 2;

    localparam logic signed [10:0] ERR_MAX = 11'sd1023;
    localparam logic signed [10:0] ERR_MIN = -11'sd1024;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 16'sd1023;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -16'sd1024;

    // Odd channels are right-hand sensors and add; even channels subtract.
    function automatic logic signed [ACC_W-1:0] weigh(input logic [2:0] ch,
                                                      input logic [11:0] rdg);
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-12){1'b0}}, rdg});
        case (ch)
            CH_IN_L, CH_IN_R:   mag = mag <<< SH_IN;
            CH_MID_L, CH_MID_R: mag = mag <<< SH_MID;
            CH_OUT_L, CH_OUT_R: mag = mag <<< SH_OUT;
            default:            mag = '0;
        endcase
        return ch[0] ? mag : -mag;
    endfunction

    function automatic logic [10:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX)
            return ERR_MAX;
        else if (a < ACC_MIN)
            return ERR_MIN;
        else
            return a[10:0];
    endfunction

endpackage

// File: rtl/err_compute_round_timer.sv
// round_timer: free-running round period counter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : counter runs while high, held at 0 while low
//   wrap       : high in the last count of each period (start-of-round request)
module round_timer #(
    parameter int unsigned ROUND_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic wrap
);

    localparam int unsigned CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == CW'(ROUND_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/err_compute.sv
// err_compute: periodic IR line-sensor scan producing a saturated steering error.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : block enable; low aborts any round and returns to IDLE
//   cnv_cmplt    : A2D conversion-complete pulse, res valid with it
//   res          : 12-bit unsigned A2D result
//   strt_cnv     : one-cycle conversion start pulse
//   chnnl        : A2D channel select, stable from strt_cnv to cnv_cmplt
//   IR_en        : IR emitter enable, high for SETTLE/CONV/WAIT
//   err_sat      : weighted right-minus-left error, 11-bit signed, saturated
//   err_vld      : one-cycle strobe when err_sat/line_present update
//   line_present : some reading reached LINE_THRES in the last full round
module err_compute
    import err_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES  = 4096,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter logic [11:0] LINE_THRES    = 12'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_en,
    output logic [10:0] err_sat,
    output logic        err_vld,
    output logic        line_present
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    logic                    wrap;
    state_t                  state;
    logic [SW-1:0]           settle_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    line_flag;
    logic                    line_nxt;

    round_timer #(
        .ROUND_CYCLES(ROUND_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .wrap  (wrap)
    );

    // Accumulator/line flag including the current reading, so the final
    // conversion can be published without an extra pipeline cycle.
    always_comb begin
        acc_nxt  = acc + weigh(chnnl, res);
        line_nxt = line_flag | (res >= LINE_THRES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            acc          <= '0;
            line_flag    <= 1'b0;
            strt_cnv     <= 1'b0;
            chnnl        <= '0;
            IR_en        <= 1'b0;
            err_sat      <= '0;
            err_vld      <= 1'b0;
            line_present <= 1'b0;
        end else if (!en) begin
            // Abort: published results are left untouched.
            state      <= IDLE;
            settle_cnt <= '0;
            strt_cnv   <= 1'b0;
            chnnl      <= '0;
            IR_en      <= 1'b0;
            err_vld    <= 1'b0;
        end else begin
            strt_cnv <= 1'b0;
            err_vld  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state      <= SETTLE;
                        IR_en      <= 1'b1;
                        acc        <= '0;
                        line_flag  <= 1'b0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state    <= CONV;
                        chnnl    <= CH_IN_L;
                        strt_cnv <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                // strt_cnv was raised on entry, so it is high exactly this cycle.
                CONV: state <= WAIT;
                WAIT: begin
                    if (cnv_cmplt) begin
                        acc       <= acc_nxt;
                        line_flag <= line_nxt;
                        if (chnnl == CH_OUT_R) begin
                            state        <= DONE;
                            err_sat      <= saturate(acc_nxt);
                            line_present <= line_nxt;
                            err_vld      <= 1'b1;
                            IR_en        <= 1'b0;
                        end else begin
                            state    <= CONV;
                            chnnl    <= chnnl + 3'd1;
                            strt_cnv <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
